bm_acc_unit: RTL and testbench

Accumulation stage directly downstream of the bitmatrix multiply unit. Each beat carries one W-packet product (the bitmatrix block for data device j multiplied by data packet j). The block XOR-accumulates K consecutive products into one coded (parity) packet group and presents it on a valid/ready output. It turns the combinational per-device products into the per-parity-device result that goes to the engine's write-back path.

---
 rtl/bm_acc_unit.sv | 115 +++++++++++
 tb/tb_bm_acc_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_acc_unit.sv
// bm_acc_unit: XOR-accumulates K consecutive bitmatrix products (one W-packet
// product per data device) into a single parity packet group and presents it
// on a one-deep valid/ready output register.
//
// Optional feature: define BM_ACC_SOP_CHECK_EN to enable the sticky sop_err
// framing check; otherwise sop_err is tied low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready product beat handshake; in_sop marks device 0 of a group
//   mult_product      W packets of PACKET_LENGTH bits from the multiply unit
//   out_valid/ready   coded group handshake
//   parity_packet     accumulated coded packets (held while stalled)
//   beat_cnt          beats accepted in the current group (0..K-1)
//   sop_err           sticky framing error
module bm_acc_unit #(
  parameter int unsigned K             = 2,
  parameter int unsigned W             = 4,
  parameter int unsigned PACKET_LENGTH = 2,
  localparam int unsigned CntW         = (K > 2) ? $clog2(K) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic [PACKET_LENGTH-1:0] mult_product  [0:W-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACKET_LENGTH-1:0] parity_packet [0:W-1],
  output logic [CntW-1:0]          beat_cnt,
  output logic                     sop_err
);

  logic [PACKET_LENGTH-1:0] acc_q    [0:W-1];
  logic [PACKET_LENGTH-1:0] acc_d    [0:W-1];
  logic [PACKET_LENGTH-1:0] parity_q [0:W-1];
  logic [PACKET_LENGTH-1:0] parity_d [0:W-1];
  logic [CntW-1:0]          beat_cnt_q, beat_cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic                     is_final;
  logic                     accept;

  always_comb begin
    is_final = (beat_cnt_q == CntW'(K - 1));
    // Only the final beat needs the output register, so only it back-pressures.
    in_ready = !(out_valid_q && !out_ready && is_final);
    accept   = in_valid && in_ready;

    acc_d       = acc_q;
    parity_d    = parity_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q && !out_ready;

    if (accept) begin
      if (is_final) begin
        for (int i = 0; i < int'(W); i++) begin
          parity_d[i] = acc_q[i] ^ mult_product[i];
        end
        out_valid_d = 1'b1;
        beat_cnt_d  = '0;
      end else begin
        for (int i = 0; i < int'(W); i++) begin
          // Beat 0 loads so stale data from a previous group never leaks in.
          acc_d[i] = (beat_cnt_q == '0) ? mult_product[i] : (acc_q[i] ^ mult_product[i]);
        end
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '{default: '0};
      parity_q    <= '{default: '0};
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      parity_q    <= parity_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BM_ACC_SOP_CHECK_EN
  logic sop_err_q, sop_err_d;

  always_comb begin
    sop_err_d = sop_err_q;
    if (accept && (in_sop != (beat_cnt_q == '0))) begin
      sop_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sop_err_q <= 1'b0;
    end else begin
      sop_err_q <= sop_err_d;
    end
  end

  assign sop_err = sop_err_q;
`else
  logic unused_in_sop;
  assign unused_in_sop = in_sop;
  assign sop_err       = 1'b0;
`endif

  assign out_valid     = out_valid_q;
  assign parity_packet = parity_q;
  assign beat_cnt      = beat_cnt_q;

endmodule

// File: tb/tb_bm_acc_unit.sv
// Directed bench for bm_acc_unit: a K=2 and a K=3 instance, W=4, PACKET_LENGTH=2.
// Packet groups are written as bytes with packet 0 in the two MSBs.
module tb_bm_acc_unit;

  localparam int unsigned W  = 4;
  localparam int unsigned PL = 2;

`ifdef BM_ACC_SOP_CHECK_EN
  localparam logic SopErrExp = 1'b1;
`else
  localparam logic SopErrExp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // K=2 instance
  logic          in_valid2, in_ready2, in_sop2, out_valid2, out_ready2, sop_err2;
  logic [PL-1:0] mp2  [0:W-1];
  logic [PL-1:0] par2 [0:W-1];
  logic [0:0]    cnt2;

  // K=3 instance
  logic          in_valid3, in_ready3, in_sop3, out_valid3, out_ready3, sop_err3;
  logic [PL-1:0] mp3  [0:W-1];
  logic [PL-1:0] par3 [0:W-1];
  logic [1:0]    cnt3;

  bm_acc_unit #(.K(2), .W(W), .PACKET_LENGTH(PL)) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid2),
    .in_ready      (in_ready2),
    .in_sop        (in_sop2),
    .mult_product  (mp2),
    .out_valid     (out_valid2),
    .out_ready     (out_ready2),
    .parity_packet (par2),
    .beat_cnt      (cnt2),
    .sop_err       (sop_err2)
  );

  bm_acc_unit #(.K(3), .W(W), .PACKET_LENGTH(PL)) u_dut3 (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid3),
    .in_ready      (in_ready3),
    .in_sop        (in_sop3),
    .mult_product  (mp3),
    .out_valid     (out_valid3),
    .out_ready     (out_ready3),
    .parity_packet (par3),
    .beat_cnt      (cnt3),
    .sop_err       (sop_err3)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pack2();
    logic [7:0] v;
    for (int i = 0; i < int'(W); i++) v[7-2*i -: 2] = par2[i];
    return v;
  endfunction

  function automatic logic [7:0] pack3();
    logic [7:0] v;
    for (int i = 0; i < int'(W); i++) v[7-2*i -: 2] = par3[i];
    return v;
  endfunction

  task automatic drive2(input logic [7:0] d, input logic sop);
    in_valid2 = 1'b1;
    in_sop2   = sop;
    for (int i = 0; i < int'(W); i++) mp2[i] = d[7-2*i -: 2];
  endtask

  task automatic drive3(input logic [7:0] d, input logic sop);
    in_valid3 = 1'b1;
    in_sop3   = sop;
    for (int i = 0; i < int'(W); i++) mp3[i] = d[7-2*i -: 2];
  endtask

  initial begin
    logic [7:0] d0, d1;
    int unsigned pulses;

    rst        = 1'b1;
    in_valid2  = 1'b0; in_sop2 = 1'b0; out_ready2 = 1'b1;
    in_valid3  = 1'b0; in_sop3 = 1'b0; out_ready3 = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      mp2[i] = '0;
      mp3[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_out_valid", 32'(out_valid2), 32'd0);
    check_eq("rst_beat_cnt",  32'(cnt2),       32'd0);
    check_eq("rst_parity",    32'(pack2()),    32'h00);
    check_eq("rst_in_ready",  32'(in_ready2),  32'd1);
    check_eq("rst_sop_err",   32'(sop_err2),   32'd0);

    // {1,2,3,0} ^ {3,3,1,2} = {2,1,2,2}
    drive2(8'h6C, 1'b1);
    tick();
    check_eq("basic_cnt1",   32'(cnt2),       32'd1);
    check_eq("basic_ov0",    32'(out_valid2), 32'd0);
    drive2(8'hF6, 1'b0);
    tick();
    in_valid2 = 1'b0;
    check_eq("basic_ov",     32'(out_valid2), 32'd1);
    check_eq("basic_parity", 32'(pack2()),    32'h9A);
    check_eq("basic_cnt0",   32'(cnt2),       32'd0);
    tick();
    check_eq("basic_drain",  32'(out_valid2), 32'd0);

    // Back-pressure: A = 12^34 = 26 stalls; B = 55^0F = 5A
    out_ready2 = 1'b0;
    drive2(8'h12, 1'b1);
    tick();
    drive2(8'h34, 1'b0);
    tick();
    check_eq("bp_a_parity", 32'(pack2()),    32'h26);
    drive2(8'h55, 1'b1);
    #1;
    check_eq("bp_b0_ready", 32'(in_ready2),  32'd1);
    tick();
    check_eq("bp_b0_cnt",   32'(cnt2),       32'd1);
    drive2(8'h0F, 1'b0);
    #1;
    check_eq("bp_b1_stall", 32'(in_ready2),  32'd0);
    tick();
    check_eq("bp_hold_par", 32'(pack2()),    32'h26);
    check_eq("bp_hold_cnt", 32'(cnt2),       32'd1);
    check_eq("bp_hold_ov",  32'(out_valid2), 32'd1);
    out_ready2 = 1'b1;
    #1;
    check_eq("bp_release",  32'(in_ready2),  32'd1);
    tick();
    in_valid2 = 1'b0;
    check_eq("bp_b_ov",     32'(out_valid2), 32'd1);
    check_eq("bp_b_parity", 32'(pack2()),    32'h5A);
    check_eq("bp_b_cnt",    32'(cnt2),       32'd0);
    tick();
    check_eq("bp_drain",    32'(out_valid2), 32'd0);

    // Continuous stream: 4 groups in 8 cycles
    pulses = 0;
    for (int g = 0; g < 4; g++) begin
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      drive2(d0, 1'b1);
      tick();
      if (out_valid2) pulses++;
      check_eq("stream_mid_ov", 32'(out_valid2), 32'd0);
      drive2(d1, 1'b0);
      tick();
      if (out_valid2) pulses++;
      check_eq("stream_parity", 32'(pack2()), 32'(d0 ^ d1));
    end
    in_valid2 = 1'b0;
    check_eq("stream_pulses", pulses, 32'd4);
    tick();

    // Reset after beat 0 discards it
    drive2(8'hFF, 1'b1);
    tick();
    in_valid2 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_cnt", 32'(cnt2),       32'd0);
    check_eq("mrst_ov",  32'(out_valid2), 32'd0);
    drive2(8'h81, 1'b1);
    tick();
    drive2(8'h18, 1'b0);
    tick();
    in_valid2 = 1'b0;
    check_eq("mrst_parity", 32'(pack2()), 32'h99);
    check_eq("mrst_sop_ok", 32'(sop_err2), 32'd0);

    // Wrong in_sop on beat 1
    drive2(8'h11, 1'b1);
    tick();
    drive2(8'h22, 1'b1);
    tick();
    in_valid2 = 1'b0;
    check_eq("sop_err",    32'(sop_err2), 32'(SopErrExp));
    check_eq("sop_parity", 32'(pack2()),  32'h33);
    tick();
    tick();
    check_eq("sop_sticky", 32'(sop_err2), 32'(SopErrExp));

    // K=3 with 2-cycle bubbles: C3^5A^0F = 96
    pulses = 0;
    for (int b = 0; b < 3; b++) begin
      case (b)
        0:       drive3(8'hC3, 1'b1);
        1:       drive3(8'h5A, 1'b0);
        default: drive3(8'h0F, 1'b0);
      endcase
      tick();
      in_valid3 = 1'b0;
      if (out_valid3) pulses++;
      if (b == 2) begin
        check_eq("k3_parity", 32'(pack3()), 32'h96);
        check_eq("k3_cnt0",   32'(cnt3),    32'd0);
      end else begin
        check_eq("k3_cnt", 32'(cnt3), 32'(b + 1));
      end
      for (int j = 0; j < 2; j++) begin
        tick();
        if (out_valid3) pulses++;
      end
    end
    check_eq("k3_pulses", pulses, 32'd1);
    check_eq("k3_sop_ok", 32'(sop_err3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
